port_pio_v2: RTL and testbench

PORT_PIO_V2 -- requirements
Module: port_pio_v2

---
 rtl/port_pio_pkg.sv | 22 ++
 rtl/port_pio_v2_if.sv | 20 ++
 rtl/pio_in_cond.sv | 62 ++++++
 rtl/port_pio_v2.sv | 107 ++++++++++
 tb/tb_port_pio_v2.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/port_pio_pkg.sv
// Shared definitions for the port_pio_v2 parallel I/O block: register map and width limits.
package port_pio_pkg;

    localparam int PIO_MAX_WIDTH = 32;
    localparam int PIO_BUS_W     = 32;

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_DIR      = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_EDGE_CAP = 3'd3,
        ADDR_OUTSET   = 3'd4,
        ADDR_OUTCLR   = 3'd5,
        ADDR_RISE_EN  = 3'd6,
        ADDR_FALL_EN  = 3'd7
    } pio_addr_e;

    function automatic bit pio_width_ok(input int w);
        return (w >= 1) && (w <= PIO_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/port_pio_v2_if.sv
// Avalon-MM slave bus bundle for port_pio_v2 (fixed read latency 1, no waitrequest).
interface port_pio_v2_if;

    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/pio_in_cond.sv
// Input conditioning: two-flop synchronizer, optional tick-sampled debouncer and edge detector.
module pio_in_cond
    import port_pio_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] db_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] s1_q, s2_q, db_q, db_d, prev_q;

    // Reset loads the whole chain from the pin so release never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= pin_i;
            s2_q   <= pin_i;
            db_q   <= pin_i;
            prev_q <= pin_i;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            db_q   <= db_d;
            prev_q <= db_q;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign db_d = s2_q;
    end else begin : g_debounce
        localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

        logic [CW-1:0]    cnt_q;
        logic [WIDTH-1:0] samp_q;
        logic [WIDTH-1:0] agree;
        logic             tick;

        assign tick  = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        assign agree = ~(s2_q ^ samp_q);
        assign db_d  = tick ? ((agree & s2_q) | (~agree & db_q)) : db_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q  <= '0;
                samp_q <= pin_i;
            end else begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
                if (tick) samp_q <= s2_q;
            end
        end
    end

    assign db_o   = db_q;
    assign rise_o = db_q & ~prev_q;
    assign fall_o = ~db_q & prev_q;

endmodule

// File: rtl/port_pio_v2.sv
// Parallel I/O port with per-bit direction, set/clear aliases and edge-capture interrupts.
module port_pio_v2
    import port_pio_pkg::*;
#(
    parameter int          WIDTH           = 32,
    parameter int          DEBOUNCE_CYCLES = 0,
    parameter logic [31:0] RESET_OUT       = 32'd0,
    parameter logic [31:0] RESET_DIR       = 32'd0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    port_pio_v2_if.slave     avs,
    output logic             irq,
    input  logic [WIDTH-1:0] port_in,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] port_oe
);

    if (!pio_width_ok(WIDTH)) begin : g_width_check
        $error("port_pio_v2: WIDTH must be 1..32");
    end

    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d, ren_q, ren_d, fen_q, fen_d;
    logic [WIDTH-1:0] wdata, w1c, rd_val, db, rise, fall;
    logic [31:0]      rdata_q, rdata_d;
    logic             unused_wdata;

    assign wdata        = avs.avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs.avs_writedata;

    pio_in_cond #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_in_cond (
        .clk_i  (clk_clk),
        .rst_i  (reset_reset),
        .pin_i  (port_in),
        .db_o   (db),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        ren_d  = ren_q;
        fen_d  = fen_q;
        w1c    = '0;
        if (avs.avs_write) begin
            case (pio_addr_e'(avs.avs_address))
                ADDR_DATA:     out_d  = wdata;
                ADDR_DIR:      dir_d  = wdata;
                ADDR_IRQ_MASK: mask_d = wdata;
                ADDR_EDGE_CAP: w1c    = wdata;
                ADDR_OUTSET:   out_d  = out_q | wdata;
                ADDR_OUTCLR:   out_d  = out_q & ~wdata;
                ADDR_RISE_EN:  ren_d  = wdata;
                ADDR_FALL_EN:  fen_d  = wdata;
                default: ;
            endcase
        end
        // Edge sets are ORed after the clear so a same-cycle edge wins.
        cap_d = (cap_q & ~w1c) | (rise & ren_q) | (fall & fen_q);
    end

    always_comb begin
        rd_val = '0;
        case (pio_addr_e'(avs.avs_address))
            ADDR_DATA:     rd_val = (db & ~dir_q) | (out_q & dir_q);
            ADDR_DIR:      rd_val = dir_q;
            ADDR_IRQ_MASK: rd_val = mask_q;
            ADDR_EDGE_CAP: rd_val = cap_q;
            ADDR_RISE_EN:  rd_val = ren_q;
            ADDR_FALL_EN:  rd_val = fen_q;
            default:       rd_val = '0;
        endcase
        rdata_d = avs.avs_read ? 32'(rd_val) : 32'd0;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            out_q   <= RESET_OUT[WIDTH-1:0];
            dir_q   <= RESET_DIR[WIDTH-1:0];
            mask_q  <= '0;
            cap_q   <= '0;
            ren_q   <= '0;
            fen_q   <= '0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            ren_q   <= ren_d;
            fen_q   <= fen_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign irq              = |(cap_q & mask_q);
    assign port_out         = out_q;
    assign port_oe          = dir_q;

endmodule

// File: tb/tb_port_pio_v2.sv
// Self-checking bench for port_pio_v2: register table, directed edge/debounce/reset sequences, random vs model.
module tb_port_pio_v2;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1, rst4 = 1'b1;
    logic [7:0] pin0 = 8'h00, pin4 = 8'h00;
    logic [7:0] out0, oe0, out4, oe4;
    logic       irq0, irq4;

    int n_cmp = 0;
    int n_bad = 0;

    port_pio_v2_if bus0 ();
    port_pio_v2_if bus4 ();

    port_pio_v2 #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .RESET_OUT(32'h0), .RESET_DIR(32'h0)) dut0 (
        .clk_clk(clk), .reset_reset(rst0), .avs(bus0), .irq(irq0),
        .port_in(pin0), .port_out(out0), .port_oe(oe0)
    );

    port_pio_v2 #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .RESET_OUT(32'h0), .RESET_DIR(32'h0)) dut4 (
        .clk_clk(clk), .reset_reset(rst4), .avs(bus4), .irq(irq4),
        .port_in(pin4), .port_out(out4), .port_oe(oe4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vt[$];

    // Reference model state (dut0)
    logic [7:0]  m_out, m_dir, m_mask, m_cap, m_ren, m_fen;
    logic [31:0] m_rd;
    logic [7:0]  hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input int sel, input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.avs_read = rd; bus0.avs_write = wr; bus0.avs_address = a; bus0.avs_writedata = d;
        end else begin
            bus4.avs_read = rd; bus4.avs_write = wr; bus4.avs_address = a; bus4.avs_writedata = d;
        end
    endtask

    task automatic wr_reg(input int sel, input logic [2:0] a, input logic [31:0] d);
        bus(sel, 1'b0, 1'b1, a, d);
        tick();
        bus(sel, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic rd_chk(input int sel, input logic [2:0] a, input logic [31:0] exp, input string name);
        bus(sel, 1'b1, 1'b0, a, 32'd0);
        tick();
        bus(sel, 1'b0, 1'b0, 3'd0, 32'd0);
        chk(name, (sel == 0) ? bus0.avs_readdata : bus4.avs_readdata, exp);
    endtask

    // Pin value seen by the edge detector at edge t is the pin sampled at t-3.
    task automatic model_edge(input logic r, input logic rd, input logic wr,
                              input logic [2:0] a, input logic [31:0] d, input logic [7:0] p);
        logic [7:0] p3, p4, wd, rv, w1c;
        if (r) begin
            m_out = 8'h00; m_dir = 8'h00; m_mask = 8'h00; m_cap = 8'h00;
            m_ren = 8'h00; m_fen = 8'h00; m_rd = 32'd0;
            hist.delete();
            repeat (5) hist.push_back(p);
            return;
        end
        hist.push_back(p);
        void'(hist.pop_front());
        p3 = hist[1];
        p4 = hist[0];
        wd = d[7:0];
        case (a)
            3'd0: rv = (p3 & ~m_dir) | (m_out & m_dir);
            3'd1: rv = m_dir;
            3'd2: rv = m_mask;
            3'd3: rv = m_cap;
            3'd6: rv = m_ren;
            3'd7: rv = m_fen;
            default: rv = 8'h00;
        endcase
        m_rd = rd ? {24'd0, rv} : 32'd0;
        w1c = (wr && a == 3'd3) ? wd : 8'h00;
        m_cap = (m_cap & ~w1c) | (p3 & ~p4 & m_ren) | (~p3 & p4 & m_fen);
        if (wr) begin
            case (a)
                3'd0: m_out  = wd;
                3'd1: m_dir  = wd;
                3'd2: m_mask = wd;
                3'd4: m_out  = m_out | wd;
                3'd5: m_out  = m_out & ~wd;
                3'd6: m_ren  = wd;
                3'd7: m_fen  = wd;
                default: ;
            endcase
        end
    endtask

    initial begin
        bus(0, 1'b0, 1'b0, 3'd0, 32'd0);
        bus(1, 1'b0, 1'b0, 3'd0, 32'd0);
        pin0 = 8'h3C;
        pin4 = 8'hFF;
        rst0 = 1'b1;
        rst4 = 1'b1;
        tick();
        tick();

        chk("reset_out", {24'd0, out0}, 32'h0);
        chk("reset_oe", {24'd0, oe0}, 32'h0);
        chk("reset_irq", {31'd0, irq0}, 32'h0);
        chk("reset_rdata", bus0.avs_readdata, 32'h0);
        chk("reset_irq4", {31'd0, irq4}, 32'h0);
        rst0 = 1'b0;
        rst4 = 1'b0;
        tick();

        // Register-map table; pins held at 0x3C since before reset
        vt.push_back('{1'b1, 1'b0, 3'd1, 32'h0000000F, 32'h0,  8'h00, 8'h0F});
        vt.push_back('{1'b1, 1'b0, 3'd0, 32'h000000A5, 32'h0,  8'hA5, 8'h0F});
        vt.push_back('{1'b0, 1'b1, 3'd0, 32'h0,        32'h35, 8'hA5, 8'h0F});
        vt.push_back('{1'b1, 1'b0, 3'd4, 32'h00000010, 32'h0,  8'hB5, 8'h0F});
        vt.push_back('{1'b1, 1'b0, 3'd5, 32'h00000001, 32'h0,  8'hB4, 8'h0F});
        vt.push_back('{1'b0, 1'b1, 3'd0, 32'h0,        32'h34, 8'hB4, 8'h0F});
        vt.push_back('{1'b0, 1'b1, 3'd4, 32'h0,        32'h0,  8'hB4, 8'h0F});
        vt.push_back('{1'b0, 1'b1, 3'd5, 32'h0,        32'h0,  8'hB4, 8'h0F});
        vt.push_back('{1'b0, 1'b1, 3'd1, 32'h0,        32'h0F, 8'hB4, 8'h0F});
        vt.push_back('{1'b1, 1'b0, 3'd0, 32'hFFFFFF00, 32'h0,  8'h00, 8'h0F});
        vt.push_back('{1'b0, 1'b1, 3'd0, 32'h0,        32'h30, 8'h00, 8'h0F});
        vt.push_back('{1'b1, 1'b0, 3'd1, 32'hFFFFFFF0, 32'h0,  8'h00, 8'hF0});
        vt.push_back('{1'b0, 1'b1, 3'd0, 32'h0,        32'h0C, 8'h00, 8'hF0});
        vt.push_back('{1'b0, 1'b1, 3'd1, 32'h0,        32'hF0, 8'h00, 8'hF0});
        vt.push_back('{1'b1, 1'b0, 3'd0, 32'h0000005A, 32'h0,  8'h5A, 8'hF0});
        vt.push_back('{1'b0, 1'b1, 3'd0, 32'h0,        32'h5C, 8'h5A, 8'hF0});
        vt.push_back('{1'b1, 1'b0, 3'd2, 32'h0000003C, 32'h0,  8'h5A, 8'hF0});
        vt.push_back('{1'b0, 1'b1, 3'd2, 32'h0,        32'h3C, 8'h5A, 8'hF0});
        vt.push_back('{1'b1, 1'b0, 3'd6, 32'h00000081, 32'h0,  8'h5A, 8'hF0});
        vt.push_back('{1'b0, 1'b1, 3'd6, 32'h0,        32'h81, 8'h5A, 8'hF0});
        vt.push_back('{1'b1, 1'b0, 3'd7, 32'h00000142, 32'h0,  8'h5A, 8'hF0});
        vt.push_back('{1'b0, 1'b1, 3'd7, 32'h0,        32'h42, 8'h5A, 8'hF0});
        vt.push_back('{1'b0, 1'b1, 3'd3, 32'h0,        32'h00, 8'h5A, 8'hF0});

        for (int i = 0; i < vt.size(); i++) begin
            bus(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data);
            tick();
            chk($sformatf("vec%0d_out", i), {24'd0, out0}, {24'd0, vt[i].exp_out});
            chk($sformatf("vec%0d_oe", i), {24'd0, oe0}, {24'd0, vt[i].exp_oe});
            if (vt[i].rd) chk($sformatf("vec%0d_rd", i), bus0.avs_readdata, vt[i].exp_rd);
        end
        bus(0, 1'b0, 1'b0, 3'd0, 32'd0);

        // Rising edge latency: sampled at N, captured at N+3
        pin0 = 8'h00;
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        wr_reg(0, 3'd6, 32'h01);
        wr_reg(0, 3'd2, 32'h01);
        tick();
        pin0 = 8'h01;
        tick();
        tick();
        tick();
        chk("edge_irq_n2", {31'd0, irq0}, 32'h0);
        tick();
        chk("edge_irq_n3", {31'd0, irq0}, 32'h1);
        rd_chk(0, 3'd3, 32'h01, "edge_cap_set");
        wr_reg(0, 3'd3, 32'h01);
        chk("w1c_irq", {31'd0, irq0}, 32'h0);
        rd_chk(0, 3'd3, 32'h00, "w1c_cap");

        // W1C in the same cycle as a new rising edge
        pin0 = 8'h00;
        repeat (6) tick();
        rd_chk(0, 3'd3, 32'h00, "fall_ignored");
        pin0 = 8'h01;
        tick();
        tick();
        tick();
        bus(0, 1'b0, 1'b1, 3'd3, 32'h01);
        tick();
        bus(0, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("edge_prio_irq", {31'd0, irq0}, 32'h1);
        rd_chk(0, 3'd3, 32'h01, "edge_prio_cap");

        // Reset asserted together with a read
        bus(0, 1'b1, 1'b0, 3'd3, 32'd0);
        rst0 = 1'b1;
        tick();
        bus(0, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("reset_mid_read", bus0.avs_readdata, 32'h0);

        // No spurious capture after reset with pins high
        pin0 = 8'hFF;
        tick();
        rst0 = 1'b0;
        wr_reg(0, 3'd6, 32'hFF);
        wr_reg(0, 3'd2, 32'hFF);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("post_reset_irq%0d", i), {31'd0, irq0}, 32'h0);
        end
        rd_chk(0, 3'd3, 32'h00, "post_reset_cap");

        // Debounce: 3-cycle glitch rejected, 12-cycle low accepted
        wr_reg(1, 3'd7, 32'h02);
        wr_reg(1, 3'd2, 32'h02);
        repeat (10) tick();
        pin4 = 8'hFD;
        repeat (3) tick();
        pin4 = 8'hFF;
        repeat (20) tick();
        chk("glitch_irq", {31'd0, irq4}, 32'h0);
        rd_chk(1, 3'd3, 32'h00, "glitch_cap");
        pin4 = 8'hFD;
        repeat (12) tick();
        pin4 = 8'hFF;
        repeat (8) tick();
        chk("stable_low_irq", {31'd0, irq4}, 32'h1);
        rd_chk(1, 3'd3, 32'h02, "stable_low_cap");

        // Randomized traffic against the reference model
        begin
            logic       r, rd, wr;
            logic [2:0] a;
            logic [31:0] d;
            rst0 = 1'b1;
            pin0 = 8'($urandom);
            model_edge(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, pin0);
            tick();
            rst0 = 1'b0;
            for (int c = 0; c < 600; c++) begin
                r  = ($urandom_range(0, 79) == 0);
                rd = 1'b0;
                wr = 1'b0;
                case ($urandom_range(0, 2))
                    1: rd = 1'b1;
                    2: wr = 1'b1;
                    default: ;
                endcase
                a = 3'($urandom_range(0, 7));
                d = $urandom;
                if ($urandom_range(0, 3) == 0) pin0 = pin0 ^ (8'h01 << $urandom_range(0, 7));
                rst0 = r;
                bus(0, rd, wr, a, d);
                model_edge(r, rd, wr, a, d, pin0);
                tick();
                chk($sformatf("rnd%0d_out", c), {24'd0, out0}, {24'd0, m_out});
                chk($sformatf("rnd%0d_oe", c), {24'd0, oe0}, {24'd0, m_dir});
                chk($sformatf("rnd%0d_irq", c), {31'd0, irq0}, {31'd0, |(m_cap & m_mask)});
                if (rd) chk($sformatf("rnd%0d_rd", c), bus0.avs_readdata, m_rd);
            end
            rst0 = 1'b0;
            bus(0, 1'b0, 1'b0, 3'd0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
